// File: rtl/sid_voice_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sid_voice_unit                                             |
// | Description : Time-shared SID voice output stage. Forms the 12-bit       |
// |               waveform DAC value from one voice's oscillator/noise state,|
// |               applies the chip-model DC offset and scales it by the      |
// |               8-bit envelope. One voice in per clk, results one clk later|
// | Optional    : SID_VOICE_FLOAT_HOLD_EN - holds the last non-zero-select   |
// |               waveform value when no waveform is selected (floating DAC).|
// | Ports       : clk, rst (async, active-high)                              |
// |               model     0 = MOS6581, 1 = MOS8580                         |
// |               waveform  {noise, pulse, saw, triangle} select             |
// |               ring_mod, ring_msb  ring modulation enable / source MSB    |
// |               test      test bit (forces pulse high)                     |
// |               acc       24-bit phase accumulator                         |
// |               pw        12-bit pulse width                               |
// |               noise     23-bit noise LFSR state                          |
// |               env       8-bit unsigned envelope level                    |
// |               osc_o     registered wav[11:4] for OSC3 readback           |
// |               voice_o   registered signed 22-bit voice sample            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sid_voice_unit #(
  parameter logic signed [12:0] DC_OFFSET_6581 = 13'sh380,
  parameter logic signed [12:0] DC_OFFSET_8580 = 13'sh000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               model,
  input  logic [3:0]         waveform,
  input  logic               ring_mod,
  input  logic               test,
  input  logic [23:0]        acc,
  input  logic               ring_msb,
  input  logic [11:0]        pw,
  input  logic [22:0]        noise,
  input  logic [7:0]         env,
  output logic [7:0]         osc_o,
  output logic signed [21:0] voice_o
);

  localparam logic signed [12:0] C_MIDSCALE = 13'sd2048;

  logic               w_tmsb;
  logic [11:0]        w_tri;
  logic [11:0]        w_saw;
  logic [11:0]        w_pul;
  logic [11:0]        w_nse;
  logic [11:0]        w_wav_sel;
  logic [11:0]        w_wav;
  logic signed [12:0] w_offset;
  logic signed [12:0] w_ws;
  logic signed [8:0]  w_env;
  logic signed [21:0] w_prod;

  // Ring modulation replaces the triangle fold bit with the XOR of the
  // modulating voice's MSB.
  assign w_tmsb = acc[23] ^ (ring_mod & ring_msb);
  assign w_tri  = {acc[22:12] ^ {11{w_tmsb}}, 1'b0};
  assign w_saw  = acc[23:12];
  assign w_pul  = (test || (acc[23:12] >= pw)) ? 12'hFFF : 12'h000;
  assign w_nse  = {noise[20], noise[18], noise[14], noise[11],
                   noise[9],  noise[5],  noise[2],  noise[0], 4'b0000};

  // Selected waveforms combine as a wired-AND; unselected ones read as all-ones.
  always_comb begin
    w_wav_sel = 12'hFFF;
    if (waveform[0]) w_wav_sel = w_wav_sel & w_tri;
    if (waveform[1]) w_wav_sel = w_wav_sel & w_saw;
    if (waveform[2]) w_wav_sel = w_wav_sel & w_pul;
    if (waveform[3]) w_wav_sel = w_wav_sel & w_nse;
  end

`ifdef SID_VOICE_FLOAT_HOLD_EN
  // Single hold register shared by all time-shared voices.
  logic [11:0] r_wav_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wav_hold <= 12'h000;
    end else if (waveform != 4'b0000) begin
      r_wav_hold <= w_wav_sel;
    end
  end

  assign w_wav = (waveform == 4'b0000) ? r_wav_hold : w_wav_sel;
`else
  assign w_wav = (waveform == 4'b0000) ? 12'h000 : w_wav_sel;
`endif

  assign w_offset = model ? DC_OFFSET_8580 : DC_OFFSET_6581;

  // Range is -2048 .. 2047 + offset, which stays inside 13-bit signed.
  assign w_ws  = $signed({1'b0, w_wav}) - C_MIDSCALE + w_offset;
  assign w_env = $signed({1'b0, env});
  // Both operands are signed, so they sign-extend to the 22-bit result.
  assign w_prod = w_ws * w_env;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      osc_o   <= 8'h00;
      voice_o <= 22'sd0;
    end else begin
      osc_o   <= w_wav[11:4];
      voice_o <= w_prod;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sid_voice_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sid_voice_unit                                          |
// | Description : Directed self-checking bench for sid_voice_unit. Inputs    |
// |               change on the falling edge; outputs are sampled on the     |
// |               next falling edge, one rising edge after they were applied.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sid_voice_unit;

  logic               clk;
  logic               rst;
  logic               model;
  logic [3:0]         waveform;
  logic               ring_mod;
  logic               test;
  logic [23:0]        acc;
  logic               ring_msb;
  logic [11:0]        pw;
  logic [22:0]        noise;
  logic [7:0]         env;
  logic [7:0]         osc_o;
  logic signed [21:0] voice_o;

  int r_tests;
  int r_fails;

  localparam logic [3:0] C_TRI = 4'b0001;
  localparam logic [3:0] C_SAW = 4'b0010;
  localparam logic [3:0] C_PUL = 4'b0100;
  localparam logic [3:0] C_NSE = 4'b1000;

  sid_voice_unit dut (
    .clk      (clk),
    .rst      (rst),
    .model    (model),
    .waveform (waveform),
    .ring_mod (ring_mod),
    .test     (test),
    .acc      (acc),
    .ring_msb (ring_msb),
    .pw       (pw),
    .noise    (noise),
    .env      (env),
    .osc_o    (osc_o),
    .voice_o  (voice_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    r_tests++;
    if (obs !== exp) begin
      r_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs are already set; let one rising edge capture them, then sample.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    model    = 1'b1;
    waveform = 4'b0000;
    ring_mod = 1'b0;
    test     = 1'b0;
    acc      = 24'h000000;
    ring_msb = 1'b0;
    pw       = 12'h000;
    noise    = 23'h000000;
    env      = 8'h00;
  endtask

  initial begin
    r_tests = 0;
    r_fails = 0;
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_osc",   int'(osc_o),   0);
    check("reset_voice", int'(voice_o), 0);
    rst = 1'b0;

    // Produce nonzero outputs, then reset asynchronously between edges.
    waveform = C_SAW; acc = 24'hFFF000; env = 8'h80; model = 1'b1;
    step();
    check("pre_rst_osc", int'(osc_o), 8'hFF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_osc",   int'(osc_o),   0);
    check("async_rst_voice", int'(voice_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // Saw, MOS8580
    step();
    check("saw_8580_osc",   int'(osc_o),   8'hFF);
    check("saw_8580_voice", int'(voice_o), 262016);
    // Saw, MOS6581 adds the 0x380 offset
    model = 1'b0;
    step();
    check("saw_6581_voice", int'(voice_o), 376704);
    // Mid-scale saw is zero output
    model = 1'b1; acc = 24'h800000; env = 8'hFF;
    step();
    check("saw_mid_osc",   int'(osc_o),   8'h80);
    check("saw_mid_voice", int'(voice_o), 0);

    // Pulse threshold boundary
    waveform = C_PUL; pw = 12'h800; acc = 24'h7FF000; env = 8'h10;
    step();
    check("pul_low_osc",   int'(osc_o),   0);
    check("pul_low_voice", int'(voice_o), -32768);
    acc = 24'h800000;
    step();
    check("pul_high_osc",   int'(osc_o),   8'hFF);
    check("pul_high_voice", int'(voice_o), 32752);
    test = 1'b1; acc = 24'h000000;
    step();
    check("pul_test_osc", int'(osc_o), 8'hFF);
    test = 1'b0;

    // Triangle and ring modulation
    waveform = C_TRI; acc = 24'h400000; env = 8'h01;
    step();
    check("tri_osc",   int'(osc_o),   8'h80);
    check("tri_voice", int'(voice_o), 0);
    ring_mod = 1'b1; ring_msb = 1'b1;
    step();
    check("tri_ring_osc",   int'(osc_o),   8'h7F);
    check("tri_ring_voice", int'(voice_o), 12'h7FE - 2048);
    ring_mod = 1'b0; ring_msb = 1'b0;

    // Noise: all-ones LFSR gives 0xFF0
    waveform = C_NSE; noise = 23'h7FFFFF;
    step();
    check("nse_osc",   int'(osc_o),   8'hFF);
    check("nse_voice", int'(voice_o), 12'hFF0 - 2048);

    // Combined saw & pulse (pw = 0 keeps pulse high)
    waveform = C_SAW | C_PUL; acc = 24'h123000; pw = 12'h000;
    step();
    check("comb_osc",   int'(osc_o),   8'h12);
    check("comb_voice", int'(voice_o), 12'h123 - 2048);

    // No waveform selected
    waveform = 4'b0000;
    step();
`ifdef SID_VOICE_FLOAT_HOLD_EN
    check("nowave_osc",   int'(osc_o),   8'h12);
    check("nowave_voice", int'(voice_o), 12'h123 - 2048);
`else
    check("nowave_osc",   int'(osc_o),   0);
    check("nowave_voice", int'(voice_o), -2048);
`endif

    // Back-to-back voices, alternating model, one result per clock
    waveform = C_SAW; env = 8'h03;
    for (int i = 0; i < 6; i++) begin
      logic [11:0] v;
      int exp_v;
      v     = 12'h100 * (i + 2) + 12'h00A * i;
      acc   = {v, 12'h000};
      model = i[0];
      exp_v = (int'(v) - 2048 + (i[0] ? 0 : 896)) * 3;
      step();
      check($sformatf("stream%0d_osc", i),   int'(osc_o),   int'(v[11:4]));
      check($sformatf("stream%0d_voice", i), int'(voice_o), exp_v);
    end

    $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
